artemis_ddr3_port_master: RTL and testbench
===========================================

ARTEMIS_DDR3_PORT_MASTER -- requirements
Module: artemis_ddr3_port_master

Interface
REQ-001 Parameter MAX_BURST, default 64, maximum words per MCB command, legal range 1..64.
REQ-002 clk  in  1  single clock for all logic and for the attached MCB port (cmd/wr/rd clocks tied to clk).
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 calibration_done  in  1  MCB ready; requests are ignored while low.
REQ-005 req_en  in  1  one-cycle transfer request strobe.
REQ-006 req_write  in  1  1 = write transfer, 0 = read transfer; sampled with req_en.
REQ-007 req_addr  in  30  word-aligned byte start address.
REQ-008 req_count  in  24  transfer length in 32-bit words.
REQ-009 busy  out  1  transfer in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 error  out  1  sticky MCB error flag.
REQ-012 usr_wr_data / usr_wr_valid / usr_wr_ready  in/in/out  32/1/1  user write stream.
REQ-013 usr_rd_data / usr_rd_valid / usr_rd_ready  out/out/in  32/1/1  user read stream.
REQ-014 p_cmd_en, p_cmd_instr[2:0], p_cmd_bl[5:0], p_cmd_byte_addr[29:0]  out  MCB command port.
REQ-015 p_cmd_full  in  1  MCB command FIFO full.
REQ-016 p_wr_en, p_wr_mask[3:0], p_wr_data[31:0]  out  MCB write port.
REQ-017 p_wr_full  in  1  MCB write FIFO full.
REQ-018 p_rd_en  out  1; p_rd_data[31:0], p_rd_empty  in  MCB read port.
REQ-019 p_wr_underrun, p_wr_error, p_rd_overflow, p_rd_error  in  1 each  MCB error flags.

Function
REQ-020 FSM states: IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DATA, DONE.
REQ-021 In IDLE, req_en with calibration_done=1 latches addr, count, and direction, and clears error; busy rises the next cycle.
REQ-022 req_en while busy, or while calibration_done=0, is ignored with no side effects.
REQ-023 req_count=0 goes IDLE->DONE directly; no MCB traffic occurs.
REQ-024 Burst length is min(remaining, MAX_BURST); p_cmd_bl = burst-1.
REQ-025 WR_FILL: usr_wr_ready = !p_wr_full; a word moves when usr_wr_valid && usr_wr_ready; p_wr_en equals that product; p_wr_mask = 4'b0000.
REQ-026 WR_FILL->WR_CMD after burst words are pushed.
REQ-027 WR_CMD: p_cmd_en is asserted for exactly one cycle when !p_cmd_full; p_cmd_instr=3'b000, p_cmd_byte_addr = current addr.
REQ-028 RD_CMD: identical handshake to WR_CMD with p_cmd_instr=3'b001; then move to RD_DATA.
REQ-029 RD_DATA: usr_rd_data = p_rd_data combinationally; usr_rd_valid = !p_rd_empty; p_rd_en = usr_rd_valid && usr_rd_ready; exit after burst pops.
REQ-030 After each command, addr += burst*4 (modulo 2^30) and remaining -= burst; when remaining is nonzero, return to WR_FILL or RD_CMD, otherwise go to DONE.
REQ-031 DONE: done=1 for one cycle; then IDLE; busy=0 in DONE.
REQ-032 Any MCB error flag high while busy sets error; error holds until the next accepted request or reset; the transfer continues.
REQ-033 Outside the owning state, p_cmd_en, p_wr_en, p_rd_en, usr_wr_ready, and usr_rd_valid are 0.

Reset
REQ-034 On rst: state=IDLE; busy, done, error, p_cmd_en, p_wr_en, p_rd_en = 0; p_cmd_instr, p_cmd_bl, p_cmd_byte_addr = 0; internal counters = 0.
REQ-035 rst mid-transfer abandons the transfer with no done pulse; MCB FIFO contents are not flushed.

Structure
REQ-036 A shared package holds the MCB instruction constants CMD_WRITE=000, CMD_READ=001, CMD_WRITE_PC=010, CMD_READ_PC=011, CMD_REFRESH=100, and the FSM state encoding.
REQ-037 The block is single-level; no sub-module is used; burst computation is inline.

Verification
REQ-038 Write: addr 0x100, count 3, MAX_BURST 64, no stalls -> 3 p_wr_en; then one p_cmd_en with instr 000, bl 2, addr 0x100; done pulse.
REQ-039 Read: addr 0, count 130, MAX_BURST 64 -> commands bl 63@0x000, bl 63@0x100, bl 1@0x200; 130 words delivered in order; one done.
REQ-040 p_wr_full held high 5 cycles mid-fill -> usr_wr_ready=0 for those cycles; no word lost or duplicated.
REQ-041 p_cmd_full high 4 cycles in WR_CMD -> p_cmd_en is delayed and then asserted exactly once.
REQ-042 req_en with count 0 -> done within 2 cycles and no p_cmd_en; a second req_en while busy -> ignored.
REQ-043 p_rd_error pulsed during a read -> error=1 through done; cleared by the next accepted request.

Source files
------------

// File: rtl/artemis_ddr3_port_master_pkg.sv
// Shared constants for the Artemis DDR3 port master: MCB command opcodes and
// the transfer FSM state encoding.
package artemis_ddr3_port_master_pkg;

    localparam logic [2:0] CMD_WRITE    = 3'b000;
    localparam logic [2:0] CMD_READ     = 3'b001;
    localparam logic [2:0] CMD_WRITE_PC = 3'b010;
    localparam logic [2:0] CMD_READ_PC  = 3'b011;
    localparam logic [2:0] CMD_REFRESH  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_FILL = 3'd1,
        ST_WR_CMD  = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/artemis_ddr3_port_master.sv
// Splits a user transfer into MCB bursts of at most MAX_BURST words and moves
// the data between the user streams and a single Spartan-6 style MCB port.
module artemis_ddr3_port_master
    import artemis_ddr3_port_master_pkg::*;
#(
    parameter int MAX_BURST = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        calibration_done,
    input  logic        req_en,
    input  logic        req_write,
    input  logic [29:0] req_addr,
    input  logic [23:0] req_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [31:0] usr_wr_data,
    input  logic        usr_wr_valid,
    output logic        usr_wr_ready,
    output logic [31:0] usr_rd_data,
    output logic        usr_rd_valid,
    input  logic        usr_rd_ready,
    output logic        p_cmd_en,
    output logic [2:0]  p_cmd_instr,
    output logic [5:0]  p_cmd_bl,
    output logic [29:0] p_cmd_byte_addr,
    input  logic        p_cmd_full,
    output logic        p_wr_en,
    output logic [3:0]  p_wr_mask,
    output logic [31:0] p_wr_data,
    input  logic        p_wr_full,
    output logic        p_rd_en,
    input  logic [31:0] p_rd_data,
    input  logic        p_rd_empty,
    input  logic        p_wr_underrun,
    input  logic        p_wr_error,
    input  logic        p_rd_overflow,
    input  logic        p_rd_error
);

    localparam logic [6:0]  MAX_BURST_W = 7'(MAX_BURST);
    localparam logic [23:0] MAX_BURST_L = 24'(MAX_BURST);

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [23:0] remaining_q, remaining_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        error_q, error_d;

    logic [6:0]  burst_s;
    logic [6:0]  cnt_inc_s;
    logic [29:0] addr_next_s;
    logic [23:0] remaining_next_s;
    logic        last_word_s;
    logic        mcb_err_s;

    // Burst sizing and the address/length bookkeeping applied after each burst.
    always_comb begin
        if (remaining_q > MAX_BURST_L) begin
            burst_s = MAX_BURST_W;
        end else begin
            burst_s = remaining_q[6:0];
        end
        cnt_inc_s        = cnt_q + 7'd1;
        last_word_s      = (cnt_inc_s == burst_s);
        addr_next_s      = addr_q + {21'd0, burst_s, 2'b00};
        remaining_next_s = remaining_q - {17'd0, burst_s};
        mcb_err_s        = p_wr_underrun | p_wr_error | p_rd_overflow | p_rd_error;
    end

    // Next-state logic and all MCB/user handshake outputs.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        cnt_d           = cnt_q;
        write_d         = write_q;
        error_d         = error_q;
        busy            = 1'b0;
        done            = 1'b0;
        usr_wr_ready    = 1'b0;
        usr_rd_valid    = 1'b0;
        p_cmd_en        = 1'b0;
        p_cmd_instr     = CMD_WRITE;
        p_cmd_bl        = 6'd0;

        if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            busy = 1'b1;
            if (mcb_err_s) begin
                error_d = 1'b1;
            end else begin
                error_d = error_q;
            end
        end else begin
            busy = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_en && calibration_done) begin
                    addr_d      = req_addr;
                    remaining_d = req_count;
                    write_d     = req_write;
                    cnt_d       = 7'd0;
                    error_d     = 1'b0;
                    if (req_count == 24'd0) begin
                        state_d = ST_DONE;
                    end else if (req_write) begin
                        state_d = ST_WR_FILL;
                    end else begin
                        state_d = ST_RD_CMD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_FILL: begin
                usr_wr_ready = !p_wr_full;
                if (usr_wr_valid && !p_wr_full) begin
                    if (last_word_s) begin
                        cnt_d   = 7'd0;
                        state_d = ST_WR_CMD;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WR_CMD: begin
                p_cmd_instr = CMD_WRITE;
                p_cmd_bl    = 6'(burst_s - 7'd1);
                if (!p_cmd_full) begin
                    p_cmd_en    = 1'b1;
                    addr_d      = addr_next_s;
                    remaining_d = remaining_next_s;
                    if (remaining_next_s != 24'd0) begin
                        state_d = ST_WR_FILL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    p_cmd_en = 1'b0;
                end
            end
            ST_RD_CMD: begin
                p_cmd_instr = CMD_READ;
                p_cmd_bl    = 6'(burst_s - 7'd1);
                if (!p_cmd_full) begin
                    p_cmd_en = 1'b1;
                    state_d  = ST_RD_DATA;
                end else begin
                    p_cmd_en = 1'b0;
                end
            end
            ST_RD_DATA: begin
                // Read bookkeeping waits until the burst is drained so burst_s stays stable.
                usr_rd_valid = !p_rd_empty;
                if (!p_rd_empty && usr_rd_ready) begin
                    if (last_word_s) begin
                        cnt_d       = 7'd0;
                        addr_d      = addr_next_s;
                        remaining_d = remaining_next_s;
                        if (remaining_next_s != 24'd0) begin
                            state_d = ST_RD_CMD;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign p_wr_en         = usr_wr_valid && usr_wr_ready;
    assign p_wr_mask       = 4'b0000;
    assign p_wr_data       = usr_wr_data;
    assign p_rd_en         = usr_rd_valid && usr_rd_ready;
    assign usr_rd_data     = p_rd_data;
    assign p_cmd_byte_addr = addr_q;
    assign error           = error_q;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 30'd0;
            remaining_q <= 24'd0;
            cnt_q       <= 7'd0;
            write_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_artemis_ddr3_port_master.sv
// Directed bench for artemis_ddr3_port_master with a small MCB port model.
module tb_artemis_ddr3_port_master;

    logic        clk;
    logic        rst;
    logic        calibration_done;
    logic        req_en;
    logic        req_write;
    logic [29:0] req_addr;
    logic [23:0] req_count;
    logic        busy, done, error;
    logic [31:0] usr_wr_data;
    logic        usr_wr_valid, usr_wr_ready;
    logic [31:0] usr_rd_data;
    logic        usr_rd_valid, usr_rd_ready;
    logic        p_cmd_en;
    logic [2:0]  p_cmd_instr;
    logic [5:0]  p_cmd_bl;
    logic [29:0] p_cmd_byte_addr;
    logic        p_cmd_full;
    logic        p_wr_en;
    logic [3:0]  p_wr_mask;
    logic [31:0] p_wr_data;
    logic        p_wr_full;
    logic        p_rd_en;
    logic [31:0] p_rd_data;
    logic        p_rd_empty;
    logic        p_wr_underrun, p_wr_error, p_rd_overflow, p_rd_error;

    int n_checks = 0;
    int n_errors = 0;

    // Port-model and monitor state, written only by the monitor process.
    int          cmd_cnt = 0;
    logic [2:0]  cmd_instr [32];
    logic [5:0]  cmd_bl    [32];
    logic [29:0] cmd_addr  [32];
    int wr_src = 0, wr_seen = 0, wr_bad = 0, mask_bad = 0;
    int rd_src = 0, rd_got = 0, rd_bad = 0, rd_avail = 0;
    int done_cnt = 0;

    logic busy_at_done, error_at_done;

    artemis_ddr3_port_master #(.MAX_BURST(64)) dut (
        .clk(clk), .rst(rst), .calibration_done(calibration_done),
        .req_en(req_en), .req_write(req_write), .req_addr(req_addr), .req_count(req_count),
        .busy(busy), .done(done), .error(error),
        .usr_wr_data(usr_wr_data), .usr_wr_valid(usr_wr_valid), .usr_wr_ready(usr_wr_ready),
        .usr_rd_data(usr_rd_data), .usr_rd_valid(usr_rd_valid), .usr_rd_ready(usr_rd_ready),
        .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
        .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
        .p_wr_en(p_wr_en), .p_wr_mask(p_wr_mask), .p_wr_data(p_wr_data), .p_wr_full(p_wr_full),
        .p_rd_en(p_rd_en), .p_rd_data(p_rd_data), .p_rd_empty(p_rd_empty),
        .p_wr_underrun(p_wr_underrun), .p_wr_error(p_wr_error),
        .p_rd_overflow(p_rd_overflow), .p_rd_error(p_rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign usr_wr_data = 32'hA000_0000 + 32'(wr_src);
    assign p_rd_data   = 32'hB000_0000 + 32'(rd_src);
    assign p_rd_empty  = (rd_avail == 0);

    // MCB port model and transfer monitor.
    always @(posedge clk) begin
        if (p_cmd_en) begin
            cmd_instr[cmd_cnt] <= p_cmd_instr;
            cmd_bl[cmd_cnt]    <= p_cmd_bl;
            cmd_addr[cmd_cnt]  <= p_cmd_byte_addr;
            cmd_cnt            <= cmd_cnt + 1;
        end
        rd_avail <= rd_avail + ((p_cmd_en && p_cmd_instr == 3'b001) ? (int'(p_cmd_bl) + 1) : 0)
                             - (p_rd_en ? 1 : 0);
        if (usr_wr_valid && usr_wr_ready) wr_src <= wr_src + 1;
        if (p_wr_en) begin
            if (p_wr_data != 32'hA000_0000 + 32'(wr_seen)) wr_bad <= wr_bad + 1;
            if (p_wr_mask != 4'b0000) mask_bad <= mask_bad + 1;
            wr_seen <= wr_seen + 1;
        end
        if (p_rd_en) rd_src <= rd_src + 1;
        if (usr_rd_valid && usr_rd_ready) begin
            if (usr_rd_data != 32'hB000_0000 + 32'(rd_got)) rd_bad <= rd_bad + 1;
            rd_got <= rd_got + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wr, input logic [29:0] a, input logic [23:0] n);
        tick();
        req_en    = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_count = n;
        tick();
        req_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                found         = 1'b1;
                busy_at_done  = busy;
                error_at_done = error;
                break;
            end
        end
        if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int cb, wb, db, rb, viol;
        rst = 1'b1; calibration_done = 1'b1; req_en = 1'b0; req_write = 1'b0;
        req_addr = 30'd0; req_count = 24'd0; usr_wr_valid = 1'b1; usr_rd_ready = 1'b1;
        p_cmd_full = 1'b0; p_wr_full = 1'b0;
        p_wr_underrun = 1'b0; p_wr_error = 1'b0; p_rd_overflow = 1'b0; p_rd_error = 1'b0;
        busy_at_done = 1'b0; error_at_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cmd_en", 32'(p_cmd_en), 32'd0);
        chk("rst_cmd_bl", 32'(p_cmd_bl), 32'd0);
        chk("rst_cmd_addr", 32'(p_cmd_byte_addr), 32'd0);
        chk("rst_cmd_instr", 32'(p_cmd_instr), 32'd0);
        chk("rst_wr_ready", 32'(usr_wr_ready), 32'd0);
        tick();
        rst = 1'b0;

        // Three-word write at 0x100.
        cb = cmd_cnt; wb = wr_seen; db = done_cnt;
        start_req(1'b1, 30'h100, 24'd3);
        @(negedge clk);
        chk("wr3_busy", 32'(busy), 32'd1);
        wait_done("wr3", 50);
        chk("wr3_busy_in_done", 32'(busy_at_done), 32'd0);
        chk("wr3_words", 32'(wr_seen - wb), 32'd3);
        chk("wr3_data", 32'(wr_bad), 32'd0);
        chk("wr3_mask", 32'(mask_bad), 32'd0);
        chk("wr3_cmds", 32'(cmd_cnt - cb), 32'd1);
        chk("wr3_instr", 32'(cmd_instr[cb]), 32'd0);
        chk("wr3_bl", 32'(cmd_bl[cb]), 32'd2);
        chk("wr3_addr", 32'(cmd_addr[cb]), 32'h100);
        chk("wr3_done", 32'(done_cnt - db), 32'd1);

        // 130-word read splits into 64/64/2.
        cb = cmd_cnt; rb = rd_got; db = done_cnt;
        start_req(1'b0, 30'h0, 24'd130);
        wait_done("rd130", 600);
        chk("rd130_cmds", 32'(cmd_cnt - cb), 32'd3);
        chk("rd130_instr0", 32'(cmd_instr[cb]), 32'd1);
        chk("rd130_bl0", 32'(cmd_bl[cb]), 32'd63);
        chk("rd130_addr0", 32'(cmd_addr[cb]), 32'h000);
        chk("rd130_bl1", 32'(cmd_bl[cb+1]), 32'd63);
        chk("rd130_addr1", 32'(cmd_addr[cb+1]), 32'h100);
        chk("rd130_bl2", 32'(cmd_bl[cb+2]), 32'd1);
        chk("rd130_addr2", 32'(cmd_addr[cb+2]), 32'h200);
        chk("rd130_words", 32'(rd_got - rb), 32'd130);
        chk("rd130_order", 32'(rd_bad), 32'd0);
        chk("rd130_done", 32'(done_cnt - db), 32'd1);

        // Write FIFO full for five cycles mid-fill.
        cb = cmd_cnt; wb = wr_seen; viol = 0;
        start_req(1'b1, 30'h40, 24'd8);
        for (int i = 0; i < 40 && (wr_seen - wb) < 3; i++) @(negedge clk);
        tick();
        p_wr_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (usr_wr_ready || p_wr_en) viol++;
        end
        tick();
        p_wr_full = 1'b0;
        wait_done("wrfull", 60);
        chk("wrfull_ready_low", 32'(viol), 32'd0);
        chk("wrfull_words", 32'(wr_seen - wb), 32'd8);
        chk("wrfull_data", 32'(wr_bad), 32'd0);
        chk("wrfull_bl", 32'(cmd_bl[cb]), 32'd7);
        chk("wrfull_addr", 32'(cmd_addr[cb]), 32'h40);

        // Command FIFO full delays the write command.
        cb = cmd_cnt; wb = wr_seen; viol = 0;
        p_cmd_full = 1'b1;
        start_req(1'b1, 30'h80, 24'd2);
        for (int i = 0; i < 40 && (wr_seen - wb) < 2; i++) @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            if (p_cmd_en) viol++;
        end
        chk("cmdfull_held", 32'(viol + cmd_cnt - cb), 32'd0);
        tick();
        p_cmd_full = 1'b0;
        wait_done("cmdfull", 30);
        chk("cmdfull_cmds", 32'(cmd_cnt - cb), 32'd1);
        chk("cmdfull_bl", 32'(cmd_bl[cb]), 32'd1);
        chk("cmdfull_addr", 32'(cmd_addr[cb]), 32'h80);

        // Zero-length request completes without MCB traffic.
        cb = cmd_cnt; db = done_cnt;
        start_req(1'b1, 30'h10, 24'd0);
        wait_done("zero", 2);
        chk("zero_cmds", 32'(cmd_cnt - cb), 32'd0);
        chk("zero_done", 32'(done_cnt - db), 32'd1);

        // Second request while busy is ignored.
        cb = cmd_cnt; db = done_cnt;
        start_req(1'b1, 30'h300, 24'd4);
        start_req(1'b0, 30'h500, 24'd1);
        wait_done("ign", 60);
        repeat (5) @(negedge clk);
        chk("ign_cmds", 32'(cmd_cnt - cb), 32'd1);
        chk("ign_instr", 32'(cmd_instr[cb]), 32'd0);
        chk("ign_addr", 32'(cmd_addr[cb]), 32'h300);
        chk("ign_done", 32'(done_cnt - db), 32'd1);
        chk("ign_idle", 32'(busy), 32'd0);

        // Request while uncalibrated is ignored.
        db = done_cnt;
        calibration_done = 1'b0;
        start_req(1'b1, 30'h0, 24'd1);
        repeat (3) @(negedge clk);
        chk("uncal_busy", 32'(busy), 32'd0);
        chk("uncal_done", 32'(done_cnt - db), 32'd0);
        calibration_done = 1'b1;

        // Read error is sticky through done and cleared by next request.
        rb = rd_got;
        start_req(1'b0, 30'h20, 24'd4);
        p_rd_error = 1'b1;
        tick();
        p_rd_error = 1'b0;
        wait_done("rderr", 60);
        chk("rderr_at_done", 32'(error_at_done), 32'd1);
        chk("rderr_words", 32'(rd_got - rb), 32'd4);
        chk("rderr_held", 32'(error), 32'd1);
        start_req(1'b1, 30'h0, 24'd0);
        @(negedge clk);
        chk("rderr_cleared", 32'(error), 32'd0);
        tick();

        // Reset mid-transfer abandons it without done.
        db = done_cnt;
        start_req(1'b1, 30'h0, 24'd20);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done_cnt - db), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
